// File: rtl/edge_pkg.sv
// Shared constants for the multi-channel edge detector (edge_detect_n / edge_chan).
package edge_pkg;

    // Per-channel edge-select mode, bits [1:0] of each channel's mode slice
    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // Default parameter values
    localparam int unsigned EDGE_CH_DEFAULT   = 4;
    localparam int unsigned EDGE_SYNC_DEFAULT = 2;
    localparam int unsigned EDGE_DB_DEFAULT   = 16;

    // Debounce counter width: max(1, clog2(db_cycles))
    function automatic int unsigned db_cnt_width(input int unsigned db_cycles);
        return (db_cycles > 1) ? $clog2(db_cycles) : 1;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// Single edge-detect channel: synchroniser, optional debounce, edge qualify, sticky pending.
// Debounce counter is built only when EDGE_DEBOUNCE_EN is defined; otherwise level follows
// the synchronised input every cycle and DB_CYCLES is ignored.
module edge_chan
    import edge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = EDGE_SYNC_DEFAULT,
    parameter int unsigned DB_CYCLES   = EDGE_DB_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sig_i,
    input  logic [1:0] mode_i,
    input  logic       clr_i,
    output logic       level_o,
    output logic       pulse_o,
    output logic       pending_o
);

    // The level register acts as the final synchroniser stage, so only SYNC_STAGES-1
    // dedicated flops sit in front of it; this keeps level latency at SYNC_STAGES edges.
    localparam int unsigned SW = SYNC_STAGES - 1;

    if (SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_bad_param
        $error("edge_chan: SYNC_STAGES must be >= 2 and DB_CYCLES >= 1");
    end

    logic [SW-1:0] sync_q;
    logic [SW-1:0] sync_d;
    logic [SW:0]   sync_ext;
    logic          s;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic          pend_q,  pend_d;
    logic          sel_rise, sel_fall;
    logic          rise, fall;

    // Synchroniser shift: new sample enters at bit 0
    always_comb begin
        sync_ext = {sync_q, sig_i};
        sync_d   = sync_ext[SW-1:0];
        s        = sync_q[SW-1];
    end

`ifdef EDGE_DEBOUNCE_EN
    localparam int unsigned        CNT_W   = db_cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Debounce: accept a changed input only after it persists DB_CYCLES cycles
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (s != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // No debounce: level follows the synchronised input every cycle
    always_comb begin
        level_d = s;
    end
`endif

    // Edge qualification against the level transition committed this edge
    always_comb begin
        sel_rise = 1'b0;
        sel_fall = 1'b0;
        case (mode_i)
            EDGE_OFF:  ;
            EDGE_RISE: sel_rise = 1'b1;
            EDGE_FALL: sel_fall = 1'b1;
            EDGE_BOTH: begin
                sel_rise = 1'b1;
                sel_fall = 1'b1;
            end
        endcase
        rise    = ~level_q & level_d;
        fall    = level_q & ~level_d;
        pulse_d = (rise & sel_rise) | (fall & sel_fall);
        // A new edge wins over a simultaneous clear
        pend_d  = pulse_d | (pend_q & ~clr_i);
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
        end
    end

    assign level_o   = level_q;
    assign pulse_o   = pulse_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/edge_detect_n.sv
// Multi-channel edge detector: CH independent edge_chan instances with per-channel mode.
// Define EDGE_DEBOUNCE_EN to build the per-channel debounce counters.
module edge_detect_n
    import edge_pkg::*;
#(
    parameter int unsigned CH          = EDGE_CH_DEFAULT,
    parameter int unsigned SYNC_STAGES = EDGE_SYNC_DEFAULT,
    parameter int unsigned DB_CYCLES   = EDGE_DB_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CH-1:0]   sig_in,
    input  logic [2*CH-1:0] mode,
    input  logic [CH-1:0]   clr,
    output logic [CH-1:0]   level_out,
    output logic [CH-1:0]   pulse_out,
    output logic [CH-1:0]   pending
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .sig_i     (sig_in[i]),
            .mode_i    (mode[2*i +: 2]),
            .clr_i     (clr[i]),
            .level_o   (level_out[i]),
            .pulse_o   (pulse_out[i]),
            .pending_o (pending[i])
        );
    end

endmodule

// File: tb/tb_edge_detect_n.sv
// Testbench for edge_detect_n; works with or without EDGE_DEBOUNCE_EN defined.
`timescale 1ns/1ps
module tb_edge_detect_n;
    import edge_pkg::*;

    localparam int unsigned CH   = 4;
    localparam int unsigned SYNC = 2;
    localparam int unsigned DB   = 16;
`ifdef EDGE_DEBOUNCE_EN
    localparam int unsigned LAT      = SYNC + DB - 1;
    localparam bit          DEBOUNCE = 1'b1;
`else
    localparam int unsigned LAT      = SYNC;
    localparam bit          DEBOUNCE = 1'b0;
`endif

    typedef struct {
        int unsigned edge_no;
        int unsigned ch;
        logic        pulse;
        logic        lvl;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [CH-1:0]   sig_in;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   level_out;
    logic [CH-1:0]   pulse_out;
    logic [CH-1:0]   pending;

    int unsigned     cyc   = 0;
    logic            rst_s = 1'b1;
    logic [CH-1:0]   clr_s = '0;

    exp_t            sb_q[$];
    logic [CH-1:0]   exp_lvl  = '0;
    logic [CH-1:0]   exp_pend = '0;
    logic [CH-1:0]   drv_lvl  = '0;
    int              pulse_cnt [CH];
    int              errors = 0;
    int              checks = 0;

    edge_detect_n #(
        .CH          (CH),
        .SYNC_STAGES (SYNC),
        .DB_CYCLES   (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sig_in    (sig_in),
        .mode      (mode),
        .clr       (clr),
        .level_out (level_out),
        .pulse_out (pulse_out),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // Edge counter plus the reset/clear values the DUT sampled on that edge
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= reset;
        clr_s <= clr;
    end

    // Advance one cycle; pop due scoreboard entries and compare all outputs
    task automatic wait_cyc();
        logic [CH-1:0] exp_pulse;
        exp_t          e;
        @(negedge clk);
        exp_pulse = '0;
        if (rst_s) begin
            sb_q.delete();
            exp_lvl  = '0;
            exp_pend = '0;
        end else begin
            while (sb_q.size() > 0 && sb_q[0].edge_no <= cyc) begin
                e = sb_q.pop_front();
                exp_lvl[e.ch]   = e.lvl;
                exp_pulse[e.ch] = e.pulse;
            end
            exp_pend = exp_pulse | (exp_pend & ~clr_s);
        end
        checks++;
        if (pulse_out !== exp_pulse) begin
            errors++;
            $display("FAIL sb_pulse cyc=%0d got=%b exp=%b", cyc, pulse_out, exp_pulse);
        end
        checks++;
        if (level_out !== exp_lvl) begin
            errors++;
            $display("FAIL sb_level cyc=%0d got=%b exp=%b", cyc, level_out, exp_lvl);
        end
        checks++;
        if (pending !== exp_pend) begin
            errors++;
            $display("FAIL sb_pending cyc=%0d got=%b exp=%b", cyc, pending, exp_pend);
        end
        for (int i = 0; i < CH; i++) begin
            if (pulse_out[i] === 1'b1) pulse_cnt[i]++;
        end
        #1;
    endtask

    task automatic wait_n(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) wait_cyc();
    endtask

    // Drive one channel; when the change will be accepted, push its expected outcome
    task automatic set_sig(input int unsigned ch, input logic v, input bit accept);
        exp_t       e;
        logic [1:0] m;
        logic       rise, fall;
        sig_in[ch] = v;
        if (accept) begin
            m         = mode[2*ch +: 2];
            rise      = !drv_lvl[ch] && v;
            fall      = drv_lvl[ch] && !v;
            e.edge_no = cyc + LAT;
            e.ch      = ch;
            e.pulse   = (rise && m[0]) || (fall && m[1]);
            e.lvl     = v;
            sb_q.push_back(e);
            drv_lvl[ch] = v;
        end
    endtask

    // Release reset; inputs held high through reset come back as fresh rising edges
    task automatic release_reset();
        reset   = 1'b0;
        drv_lvl = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (sig_in[i]) set_sig(i, 1'b1, 1'b1);
        end
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb_q.size() > 0 && n < LAT + 50) begin
            wait_cyc();
            n++;
        end
        wait_cyc();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout left=%0d exp=0", sb_q.size());
        end
    endtask

    task automatic clear_pending();
        clr = '1;
        wait_cyc();
        clr = '0;
        checks++;
        if (pending !== '0) begin
            errors++;
            $display("FAIL clear_all pending got=%b exp=0000", pending);
        end
    endtask

    task automatic zero_counts();
        for (int i = 0; i < CH; i++) pulse_cnt[i] = 0;
    endtask

    task automatic test_reset();
        wait_n(2);
        checks++;
        if ({level_out, pulse_out, pending} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", {level_out, pulse_out, pending});
        end
        release_reset();
        wait_cyc();
        checks++;
        if (pulse_out !== '0) begin
            errors++;
            $display("FAIL reset_release_pulse got=%b exp=0000", pulse_out);
        end
    endtask

    task automatic test_rise_latency();
        mode = {EDGE_RISE, EDGE_RISE, EDGE_RISE, EDGE_RISE};
        zero_counts();
        set_sig(0, 1'b1, 1'b1);
        wait_n(LAT - 1);
        checks++;
        if (pulse_out !== 4'b0000) begin
            errors++;
            $display("FAIL rise_early got=%b exp=0000", pulse_out);
        end
        wait_cyc();
        checks++;
        if (pulse_out !== 4'b0001 || pending !== 4'b0001 || level_out !== 4'b0001) begin
            errors++;
            $display("FAIL rise_latency pulse=%b pend=%b lvl=%b exp=0001 each", pulse_out, pending, level_out);
        end
        wait_cyc();
        checks++;
        if (pulse_out !== 4'b0000 || pending !== 4'b0001) begin
            errors++;
            $display("FAIL rise_one_cycle pulse=%b pend=%b exp=0000/0001", pulse_out, pending);
        end
        set_sig(0, 1'b0, 1'b1);
        drain();
        checks++;
        if (pulse_cnt[0] != 1) begin
            errors++;
            $display("FAIL rise_count got=%0d exp=1", pulse_cnt[0]);
        end
        clear_pending();
    endtask

    task automatic test_glitch();
        zero_counts();
        set_sig(1, 1'b1, !DEBOUNCE);
        wait_n(DB - 1);
        set_sig(1, 1'b0, !DEBOUNCE);
        wait_n(LAT + 5);
        checks++;
        if (pulse_cnt[1] != (DEBOUNCE ? 0 : 1) || level_out[1] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_short pulses=%0d lvl=%b exp=%0d/0", pulse_cnt[1], level_out[1], DEBOUNCE ? 0 : 1);
        end
        zero_counts();
        set_sig(1, 1'b1, 1'b1);
        wait_n(DB);
        set_sig(1, 1'b0, 1'b1);
        drain();
        checks++;
        if (pulse_cnt[1] != 1) begin
            errors++;
            $display("FAIL glitch_min_width pulses=%0d exp=1", pulse_cnt[1]);
        end
        clear_pending();
    endtask

    task automatic test_modes();
        mode = {EDGE_OFF, EDGE_BOTH, EDGE_FALL, EDGE_RISE};
        zero_counts();
        for (int unsigned i = 0; i < CH; i++) set_sig(i, 1'b1, 1'b1);
        wait_n(40);
        checks++;
        if (level_out !== 4'b1111) begin
            errors++;
            $display("FAIL modes_level_hi got=%b exp=1111", level_out);
        end
        for (int unsigned i = 0; i < CH; i++) set_sig(i, 1'b0, 1'b1);
        wait_n(40);
        checks++;
        if (level_out !== 4'b0000) begin
            errors++;
            $display("FAIL modes_level_lo got=%b exp=0000", level_out);
        end
        checks++;
        if (pulse_cnt[0] != 1 || pulse_cnt[1] != 1 || pulse_cnt[2] != 2 || pulse_cnt[3] != 0) begin
            errors++;
            $display("FAIL modes_counts got=%0d,%0d,%0d,%0d exp=1,1,2,0",
                     pulse_cnt[0], pulse_cnt[1], pulse_cnt[2], pulse_cnt[3]);
        end
        clear_pending();
    endtask

    task automatic test_pending_clear();
        set_sig(2, 1'b1, 1'b1);
        wait_n(LAT);
        checks++;
        if (pending[2] !== 1'b1) begin
            errors++;
            $display("FAIL pend_set got=%b exp=1", pending[2]);
        end
        clr = 4'b0100;
        wait_cyc();
        clr = '0;
        checks++;
        if (pending[2] !== 1'b0) begin
            errors++;
            $display("FAIL pend_clear got=%b exp=0", pending[2]);
        end
        set_sig(2, 1'b0, 1'b1);
        wait_n(LAT - 1);
        clr = 4'b0100;
        wait_cyc();
        clr = '0;
        checks++;
        if (pending[2] !== 1'b1 || pulse_out[2] !== 1'b1) begin
            errors++;
            $display("FAIL pend_set_wins pend=%b pulse=%b exp=1/1", pending[2], pulse_out[2]);
        end
        drain();
        clear_pending();
    endtask

    task automatic test_mid_reset();
        mode = {EDGE_RISE, EDGE_RISE, EDGE_RISE, EDGE_RISE};
        set_sig(0, 1'b1, 1'b1);
        wait_n(10);
        reset = 1'b1;
        wait_cyc();
        checks++;
        if ({level_out, pulse_out, pending} !== '0) begin
            errors++;
            $display("FAIL midreset_debounce got=%b exp=0", {level_out, pulse_out, pending});
        end
        release_reset();
        wait_n(LAT - 1);
        checks++;
        if (pulse_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_restart_early got=%b exp=0", pulse_out[0]);
        end
        wait_cyc();
        checks++;
        if (pulse_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_restart got=%b exp=1", pulse_out[0]);
        end
        set_sig(0, 1'b0, 1'b1);
        drain();
        set_sig(0, 1'b1, 1'b1);
        wait_n(LAT);
        reset = 1'b1;
        wait_cyc();
        checks++;
        if ({level_out, pulse_out, pending} !== '0) begin
            errors++;
            $display("FAIL midreset_pulse got=%b exp=0", {level_out, pulse_out, pending});
        end
        release_reset();
        drain();
        set_sig(0, 1'b0, 1'b1);
        drain();
        clear_pending();
    endtask

    task automatic test_back_to_back();
        mode = {EDGE_OFF, EDGE_OFF, EDGE_OFF, EDGE_BOTH};
        zero_counts();
        set_sig(0, 1'b1, !DEBOUNCE);
        wait_cyc();
        set_sig(0, 1'b0, !DEBOUNCE);
        wait_n(LAT + 3);
        checks++;
        if (pulse_cnt[0] != (DEBOUNCE ? 0 : 2)) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=%0d", pulse_cnt[0], DEBOUNCE ? 0 : 2);
        end
        drain();
        clear_pending();
    endtask

    initial begin
        reset  = 1'b1;
        sig_in = '0;
        mode   = '0;
        clr    = '0;
        zero_counts();
        #2;
        test_reset();
        test_rise_latency();
        test_glitch();
        test_modes();
        test_pending_clear();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
